// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction classes and pipeline-register payloads for pipe_mips32_core.
// MUL is only decoded as an arithmetic op when MIPS32_MUL_EN is defined.
package mips32_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // NOP_INSN is zero so an all-zero pipeline register is a bubble.
    typedef enum logic [2:0] {
        NOP_INSN = 3'd0,
        RR_ALU   = 3'd1,
        RM_ALU   = 3'd2,
        LOAD     = 3'd3,
        STORE    = 3'd4,
        BRANCH   = 3'd5,
        HALT     = 3'd6
    } itype_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_MUL = 3'd5
    } alu_op_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
    } if_id_t;

    typedef struct packed {
        itype_e          itype;
        logic            is_beqz;
        alu_op_e         alu_op;
        logic [RW-1:0]   rs;
        logic [RW-1:0]   rt;
        logic [RW-1:0]   dst;
        logic            wr_en;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] npc;
    } id_ex_t;

    typedef struct packed {
        itype_e          itype;
        logic [RW-1:0]   dst;
        logic            wr_en;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] sdata;
    } ex_mem_t;

    typedef struct packed {
        itype_e          itype;
        logic [RW-1:0]   dst;
        logic            wr_en;
        logic [XLEN-1:0] result;
    } mem_wb_t;

    function automatic itype_e decode_type(input logic [5:0] op);
        itype_e t;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: t = RR_ALU;
`ifdef MIPS32_MUL_EN
            OP_MUL:                                t = RR_ALU;
`endif
            OP_ADDI, OP_SUBI, OP_SLTI:             t = RM_ALU;
            OP_LW:                                 t = LOAD;
            OP_SW:                                 t = STORE;
            OP_BNEQZ, OP_BEQZ:                     t = BRANCH;
            OP_HLT:                                t = HALT;
            default:                               t = NOP_INSN;
        endcase
        return t;
    endfunction

    function automatic alu_op_e alu_op_of(input logic [5:0] op);
        alu_op_e a;
        case (op)
            OP_SUB, OP_SUBI: a = ALU_SUB;
            OP_AND:          a = ALU_AND;
            OP_OR:           a = ALU_OR;
            OP_SLT, OP_SLTI: a = ALU_SLT;
            OP_MUL:          a = ALU_MUL;
            default:         a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational ALU for pipe_mips32_core; the signed multiplier exists only
// when MIPS32_MUL_EN is defined.
module mips32_alu
    import mips32_pkg::*;
(
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_SLT: y_o = {(XLEN-1)'(0), ($signed(a_i) < $signed(b_i))};
`ifdef MIPS32_MUL_EN
            ALU_MUL: y_o = XLEN'($signed(a_i) * $signed(b_i));
`endif
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/pipe_mips32_core.sv
// 5-stage pipelined MIPS32 subset core with one unified code/data word memory.
// Define MIPS32_MUL_EN to implement MUL; otherwise MUL executes as a NOP.
module pipe_mips32_core
    import mips32_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic clk1,
    input  logic rst_n,
    output logic halted
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    // Architectural state; names are fixed for hierarchical preload/inspection.
    logic [XLEN-1:0] Reg [0:31];
    logic [XLEN-1:0] Mem [0:MEM_WORDS-1];
    logic [XLEN-1:0] PC;
    logic            HALTED;
    logic            TAKEN_BRANCH;

    logic [XLEN-1:0] pc_d;
    logic            halted_d;
    logic            taken_d;

    if_id_t  if_id_q,  if_id_d;
    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    // Write-back enable, shared by the register file write and all bypasses.
    logic wb_we_c;
    assign wb_we_c = mem_wb_q.wr_en && !HALTED;

    // Fetch
    logic [XLEN-1:0] fetch_ir_c;
    assign fetch_ir_c = Mem[PC[AW-1:0]];

    // Decode with a write-first register file
    logic [5:0]      id_op_c;
    logic [RW-1:0]   id_rs_c;
    logic [RW-1:0]   id_rt_c;
    logic [RW-1:0]   id_rd_c;
    logic [XLEN-1:0] id_imm_c;
    logic [XLEN-1:0] id_a_c;
    logic [XLEN-1:0] id_b_c;
    itype_e          id_type_c;
    id_ex_t          id_dec_c;

    assign id_op_c   = if_id_q.ir[31:26];
    assign id_rs_c   = if_id_q.ir[25:21];
    assign id_rt_c   = if_id_q.ir[20:16];
    assign id_rd_c   = if_id_q.ir[15:11];
    assign id_imm_c  = {{16{if_id_q.ir[15]}}, if_id_q.ir[15:0]};
    assign id_type_c = if_id_q.valid ? decode_type(id_op_c) : NOP_INSN;

    assign id_a_c = (id_rs_c == '0) ? '0 :
                    (wb_we_c && mem_wb_q.dst == id_rs_c) ? mem_wb_q.result : Reg[id_rs_c];
    assign id_b_c = (id_rt_c == '0) ? '0 :
                    (wb_we_c && mem_wb_q.dst == id_rt_c) ? mem_wb_q.result : Reg[id_rt_c];

    always_comb begin
        id_dec_c         = '0;
        id_dec_c.itype   = id_type_c;
        id_dec_c.is_beqz = (id_op_c == OP_BEQZ);
        id_dec_c.alu_op  = alu_op_of(id_op_c);
        id_dec_c.rs      = id_rs_c;
        id_dec_c.rt      = id_rt_c;
        id_dec_c.dst     = (id_type_c == RR_ALU) ? id_rd_c : id_rt_c;
        id_dec_c.wr_en   = (id_type_c == RR_ALU || id_type_c == RM_ALU || id_type_c == LOAD)
                           && (id_dec_c.dst != '0);
        id_dec_c.a       = id_a_c;
        id_dec_c.b       = id_b_c;
        id_dec_c.imm     = id_imm_c;
        id_dec_c.npc     = if_id_q.npc;
    end

    // Execute: EX/MEM ALU result beats MEM/WB, which beats the ID-stage read.
    // A load sitting in EX/MEM has no data yet, so it is never a bypass source.
    logic            fwd_mem_a_c;
    logic            fwd_mem_b_c;
    logic [XLEN-1:0] ex_a_c;
    logic [XLEN-1:0] ex_b_c;
    logic [XLEN-1:0] alu_b_c;
    logic [XLEN-1:0] alu_y_c;
    logic [XLEN-1:0] br_target_c;
    logic            br_taken_c;

    assign fwd_mem_a_c = ex_mem_q.wr_en && (ex_mem_q.itype != LOAD) && (ex_mem_q.dst == id_ex_q.rs);
    assign fwd_mem_b_c = ex_mem_q.wr_en && (ex_mem_q.itype != LOAD) && (ex_mem_q.dst == id_ex_q.rt);

    assign ex_a_c = fwd_mem_a_c ? ex_mem_q.alu :
                    (wb_we_c && mem_wb_q.dst == id_ex_q.rs) ? mem_wb_q.result : id_ex_q.a;
    assign ex_b_c = fwd_mem_b_c ? ex_mem_q.alu :
                    (wb_we_c && mem_wb_q.dst == id_ex_q.rt) ? mem_wb_q.result : id_ex_q.b;

    assign alu_b_c     = (id_ex_q.itype == RR_ALU) ? ex_b_c : id_ex_q.imm;
    assign br_target_c = id_ex_q.npc + id_ex_q.imm;
    assign br_taken_c  = (id_ex_q.itype == BRANCH) && !HALTED &&
                         (id_ex_q.is_beqz ? (ex_a_c == '0) : (ex_a_c != '0));

    mips32_alu u_alu (
        .op_i (id_ex_q.alu_op),
        .a_i  (ex_a_c),
        .b_i  (alu_b_c),
        .y_o  (alu_y_c)
    );

    // Memory access
    logic [AW-1:0]   mem_addr_c;
    logic [XLEN-1:0] mem_result_c;
    logic            mem_we_c;

    assign mem_addr_c   = ex_mem_q.alu[AW-1:0];
    assign mem_result_c = (ex_mem_q.itype == LOAD) ? Mem[mem_addr_c] : ex_mem_q.alu;
    assign mem_we_c     = (ex_mem_q.itype == STORE) && !HALTED;

    // Fetch stops while a HLT is anywhere from ID onward, or once halted.
    logic stop_fetch_c;
    assign stop_fetch_c = (id_dec_c.itype == HALT) || (id_ex_q.itype == HALT) ||
                          (ex_mem_q.itype == HALT) || (mem_wb_q.itype == HALT);

    always_comb begin
        pc_d     = PC;
        halted_d = HALTED;
        taken_d  = 1'b0;
        if_id_d  = '0;
        id_ex_d  = '0;
        ex_mem_d = '0;
        mem_wb_d = '0;
        if (!HALTED) begin
            halted_d = (mem_wb_q.itype == HALT);

            mem_wb_d.itype  = ex_mem_q.itype;
            mem_wb_d.dst    = ex_mem_q.dst;
            mem_wb_d.wr_en  = ex_mem_q.wr_en;
            mem_wb_d.result = mem_result_c;

            ex_mem_d.itype  = id_ex_q.itype;
            ex_mem_d.dst    = id_ex_q.dst;
            ex_mem_d.wr_en  = id_ex_q.wr_en;
            ex_mem_d.alu    = alu_y_c;
            ex_mem_d.sdata  = ex_b_c;

            // A taken branch squashes IF/ID and ID/EX, including any HLT there.
            if (br_taken_c) begin
                pc_d    = br_target_c;
                taken_d = 1'b1;
            end else if (stop_fetch_c) begin
                id_ex_d = id_dec_c;
            end else begin
                pc_d          = PC + XLEN'(1);
                if_id_d.valid = 1'b1;
                if_id_d.ir    = fetch_ir_c;
                if_id_d.npc   = PC + XLEN'(1);
                id_ex_d       = id_dec_c;
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            if_id_q      <= '0;
            id_ex_q      <= '0;
            ex_mem_q     <= '0;
            mem_wb_q     <= '0;
        end else begin
            PC           <= pc_d;
            HALTED       <= halted_d;
            TAKEN_BRANCH <= taken_d;
            if_id_q      <= if_id_d;
            id_ex_q      <= id_ex_d;
            ex_mem_q     <= ex_mem_d;
            mem_wb_q     <= mem_wb_d;
        end
    end

    // Register file and memory keep their contents across reset.
    always_ff @(posedge clk1) begin
        if (wb_we_c) begin
            Reg[mem_wb_q.dst] <= mem_wb_q.result;
        end
        if (mem_we_c) begin
            Mem[mem_addr_c] <= ex_mem_q.sdata;
        end
    end

    assign halted = HALTED;

endmodule

// File: tb/tb_pipe_mips32_core.sv
// Directed-program bench for pipe_mips32_core with a queued-expectation scoreboard.
module tb_pipe_mips32_core;

    localparam int MEM_WORDS = 1024;
    localparam int HALT_BUDGET = 400;

    localparam int K_REG   = 0;
    localparam int K_MEM   = 1;
    localparam int K_HALT  = 2;
    localparam int K_PC    = 3;
    localparam int K_TAKEN = 4;

    logic clk1;
    logic rst_n;
    logic halted;

    pipe_mips32_core #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .halted (halted)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] val;
        int          delay;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog[$];
    int          vectors;
    int          miscompares;
    bit          busy;
    bit          immediate;
    int          taken_cnt;

    // Counts taken-branch pulses since the last reset.
    always @(negedge clk1) begin
        if (!rst_n) taken_cnt <= 0;
        else if (dut.TAKEN_BRANCH) taken_cnt <= taken_cnt + 1;
    end

    task automatic expect_val(input string name, input int kind, input int idx,
                              input logic [31:0] val, input int delay);
        exp_t e;
        e.name = name; e.kind = kind; e.idx = idx; e.val = val; e.delay = delay;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int kind, input int idx);
        logic [31:0] v;
        case (kind)
            K_REG:   v = dut.Reg[idx];
            K_MEM:   v = dut.Mem[idx];
            K_HALT:  v = {31'b0, halted};
            K_PC:    v = dut.PC;
            default: v = 32'(taken_cnt);
        endcase
        return v;
    endfunction

    // Monitor: waits for halted (unless checking immediately), then drains the queue.
    initial begin : monitor
        int          n;
        exp_t        e;
        logic [31:0] act;
        forever begin
            wait (busy);
            if (!immediate) begin
                n = 0;
                while (!halted && n < HALT_BUDGET) begin
                    @(negedge clk1);
                    n++;
                end
                if (!halted) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL halt_timeout: halted=%0b after %0d cycles, required 1", halted, n);
                end
            end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                repeat (e.delay) @(negedge clk1);
                act = observe(e.kind, e.idx);
                vectors++;
                if (act !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got %h, required %h", e.name, act, e.val);
                end
            end
            busy = 1'b0;
        end
    end

    task automatic setup();
        rst_n = 1'b0;
        @(negedge clk1);
        for (int i = 0; i < 32; i++) dut.Reg[i] = 32'(i);
        for (int i = 0; i < MEM_WORDS; i++) dut.Mem[i] = '0;
        for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
    endtask

    task automatic release_reset();
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic run_check(input bit imm);
        immediate = imm;
        busy = 1'b1;
        wait (!busy);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rst_n = 1'b0;
        busy = 1'b0;
        immediate = 1'b0;
        vectors = 0;
        miscompares = 0;

        // Load, add, store through a filler-separated program
        prog = {32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
                32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        setup();
        dut.Mem[120] = 32'd85;
        expect_val("lw_sw_mem121", K_MEM, 121, 32'd130, 0);
        expect_val("lw_sw_mem120", K_MEM, 120, 32'd85, 0);
        expect_val("lw_sw_r1", K_REG, 1, 32'd120, 0);
        expect_val("lw_sw_r2", K_REG, 2, 32'd130, 0);
        expect_val("lw_sw_halted", K_HALT, 0, 32'd1, 0);
        expect_val("lw_sw_pc", K_PC, 0, 32'd8, 0);
        release_reset();
        run_check(1'b0);

        // Simple RR add from preloaded registers
        prog = {32'h00222000, 32'hfc000000};
        setup();
        expect_val("add_r4", K_REG, 4, 32'd3, 0);
        expect_val("add_pc", K_PC, 0, 32'd2, 0);
        release_reset();
        run_check(1'b0);

        // Back-to-back EX/MEM forwarding
        prog = {32'h2801000a, 32'h28220014, 32'hfc000000};
        setup();
        expect_val("fwd_r1", K_REG, 1, 32'd10, 0);
        expect_val("fwd_r2", K_REG, 2, 32'd30, 0);
        release_reset();
        run_check(1'b0);

        // Taken BNEQZ skips two instructions
        prog = {32'h28010001, 32'h34200002, 32'h28050007, 32'h28060007, 32'hfc000000};
        setup();
        expect_val("bneqz_r1", K_REG, 1, 32'd1, 0);
        expect_val("bneqz_r5", K_REG, 5, 32'd5, 0);
        expect_val("bneqz_r6", K_REG, 6, 32'd6, 0);
        expect_val("bneqz_taken", K_TAKEN, 0, 32'd1, 0);
        expect_val("bneqz_halted", K_HALT, 0, 32'd1, 0);
        release_reset();
        run_check(1'b0);

        // Not-taken BEQZ falls through without penalty
        prog = {32'h28010001, 32'h38200002, 32'h28050007, 32'h28060007, 32'hfc000000};
        setup();
        expect_val("beqz_r5", K_REG, 5, 32'd7, 0);
        expect_val("beqz_r6", K_REG, 6, 32'd7, 0);
        expect_val("beqz_taken", K_TAKEN, 0, 32'd0, 0);
        release_reset();
        run_check(1'b0);

        // ALU ops, signed compares, R0 discard, write-first register file
        prog = {32'h04A95800, 32'h11616000, 32'h08C36800, 32'h316EFFFB,
                32'h2C0F0001, 32'h28000005, 32'h00008000, 32'h0DED8800, 32'hfc000000};
        setup();
        expect_val("sub_r11", K_REG, 11, 32'hFFFFFFFC, 0);
        expect_val("slt_r12", K_REG, 12, 32'd1, 0);
        expect_val("and_r13", K_REG, 13, 32'd2, 0);
        expect_val("slti_r14", K_REG, 14, 32'd0, 0);
        expect_val("subi_r15", K_REG, 15, 32'hFFFFFFFF, 0);
        expect_val("r0_zero", K_REG, 0, 32'd0, 0);
        expect_val("add_r0_r16", K_REG, 16, 32'd0, 0);
        expect_val("or_r17", K_REG, 17, 32'hFFFFFFFF, 0);
        release_reset();
        run_check(1'b0);

        // Reset mid-run, then rerun to HLT and check that nothing moves afterwards
        prog = {32'h280A0063};
        repeat (20) prog.push_back(32'h0c631800);
        prog.push_back(32'hfc000000);
        prog.push_back(32'h240A0032);
        prog.push_back(32'h28130007);
        setup();
        release_reset();
        repeat (12) @(negedge clk1);
        rst_n = 1'b0;
        #1;
        expect_val("rst_pc", K_PC, 0, 32'd0, 0);
        expect_val("rst_halted", K_HALT, 0, 32'd0, 0);
        expect_val("rst_keeps_r10", K_REG, 10, 32'd99, 0);
        expect_val("rst_keeps_mem0", K_MEM, 0, 32'h280A0063, 0);
        run_check(1'b1);
        expect_val("hlt_pc", K_PC, 0, 32'd22, 0);
        expect_val("hlt_mem50", K_MEM, 50, 32'd0, 0);
        expect_val("hlt_pc_20cyc", K_PC, 0, 32'd22, 20);
        expect_val("hlt_mem50_20cyc", K_MEM, 50, 32'd0, 0);
        expect_val("hlt_mem21_20cyc", K_MEM, 21, 32'hfc000000, 0);
        expect_val("hlt_r19_20cyc", K_REG, 19, 32'd19, 0);
        expect_val("hlt_halted_20cyc", K_HALT, 0, 32'd1, 0);
        release_reset();
        run_check(1'b0);

        // MUL depends on build configuration
        prog = {32'h14433800, 32'hfc000000};
        setup();
`ifdef MIPS32_MUL_EN
        expect_val("mul_r7", K_REG, 7, 32'd6, 0);
`else
        expect_val("mul_r7", K_REG, 7, 32'd7, 0);
`endif
        release_reset();
        run_check(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
